// File: rtl/cpu_bus_pkg.sv
// Shared definitions for the SRAM-like bus arbiter: FSM states, owner tags, size codes.
package cpu_bus_pkg;

  // IDLE   : free to arbitrate, winner picked combinationally
  // LOCK_I : fetch granted, waiting for bus_addr_ok
  // LOCK_D : load/store granted, waiting for bus_addr_ok
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOCK_I = 2'd1,
    LOCK_D = 2'd2
  } arb_state_t;

  typedef enum logic {
    OWN_I = 1'b0,
    OWN_D = 1'b1
  } owner_t;

  localparam logic [1:0] SZ_WORD = 2'b10;

endpackage

// File: rtl/owner_fifo.sv
// In-order tracker of accepted bus transactions: one {owner, drop} entry per
// outstanding request. Fetch entries can be marked dropped by a pipeline kill
// so their responses are swallowed when they reach the head.
module owner_fifo
  import cpu_bus_pkg::*;
#(
  parameter int DEPTH = 2,
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          push,
  input  owner_t        push_owner,
  input  logic          pop,
  input  logic          kill_inst,
  output owner_t        head_owner,
  output logic          head_drop,
  output logic [CW-1:0] count
);

  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  owner_t           own_q [DEPTH];
  logic [DEPTH-1:0] drop_q;
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             push_ok;
  logic             pop_ok;

  // A response with nothing outstanding is ignored; a full FIFO never takes a push.
  assign push_ok = push && (count != DEPTH_C);
  assign pop_ok  = pop && (count != '0);

  assign head_owner = own_q[rd_ptr];
  assign head_drop  = drop_q[rd_ptr];

  // Entry storage, kill marking and pointer/occupancy bookkeeping.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < DEPTH; i++) own_q[i] <= OWN_I;
      drop_q <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (kill_inst && own_q[i] == OWN_I) drop_q[i] <= 1'b1;
      end
      if (push_ok) begin
        own_q[wr_ptr]  <= push_owner;
        drop_q[wr_ptr] <= kill_inst && (push_owner == OWN_I);
        wr_ptr         <= wr_ptr + 1'b1;
      end
      if (pop_ok) rd_ptr <= rd_ptr + 1'b1;
      unique case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

`ifndef SYNTHESIS
  // Bus agent must never answer when nothing is outstanding.
  assert property (@(posedge clk) disable iff (!resetn) !(pop && count == '0))
    else $error("owner_fifo: bus_data_ok with no outstanding transaction");
`endif

endmodule

// File: rtl/sram_bus_arbiter.sv
// Arbiter merging a fetch port and a load/store port onto one SRAM-like bus.
// Build option: define ARB_RR_EN for round-robin arbitration; otherwise data
// always wins over fetch.
module sram_bus_arbiter
  import cpu_bus_pkg::*;
#(
  parameter int OUTST_DEPTH = 2
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        inst_req,
  input  logic [31:0] inst_addr,
  output logic        inst_addr_ok,
  output logic        inst_data_ok,
  output logic [31:0] inst_rdata,
  input  logic        inst_kill,
  input  logic        data_req,
  input  logic        data_wr,
  input  logic [1:0]  data_size,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  output logic [31:0] data_rdata,
  output logic        bus_req,
  output logic        bus_wr,
  output logic [1:0]  bus_size,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  input  logic        bus_addr_ok,
  input  logic        bus_data_ok,
  input  logic [31:0] bus_rdata
);

  localparam int CW = $clog2(OUTST_DEPTH) + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(OUTST_DEPTH);

  arb_state_t    state;
  arb_state_t    state_nxt;
  owner_t        grant;
  owner_t        head_owner;
  logic          head_drop;
  logic          grant_req;
  logic          space;
  logic          accept;
  logic          pop_ok;
  logic [CW-1:0] count;

`ifdef ARB_RR_EN
  logic rr_data;
`endif

  // Winner selection: frozen while locked, arbitrated when idle.
  always_comb begin
    grant = OWN_D;
    unique case (state)
      LOCK_I: grant = OWN_I;
      LOCK_D: grant = OWN_D;
      default: begin
`ifdef ARB_RR_EN
        if (inst_req && data_req) grant = rr_data ? OWN_D : OWN_I;
        else                      grant = data_req ? OWN_D : OWN_I;
`else
        grant = data_req ? OWN_D : OWN_I;
`endif
      end
    endcase
  end

  // Occupancy comes from registered state only, so a same-cycle response
  // cannot open a slot for a new request.
  assign space     = count < DEPTH_C;
  assign grant_req = (grant == OWN_D) ? data_req : inst_req;
  assign bus_req   = resetn && grant_req && space;
  assign accept    = bus_req && bus_addr_ok;

  assign bus_wr    = (grant == OWN_D) ? data_wr    : 1'b0;
  assign bus_size  = (grant == OWN_D) ? data_size  : SZ_WORD;
  assign bus_addr  = (grant == OWN_D) ? data_addr  : inst_addr;
  assign bus_wdata = (grant == OWN_D) ? data_wdata : 32'h0;

  assign inst_addr_ok = accept && (grant == OWN_I);
  assign data_addr_ok = accept && (grant == OWN_D);

  // A kill in the pop cycle also suppresses a fetch head not yet marked dropped.
  assign pop_ok       = resetn && bus_data_ok && (count != '0);
  assign inst_data_ok = pop_ok && (head_owner == OWN_I) && !head_drop && !inst_kill;
  assign data_data_ok = pop_ok && (head_owner == OWN_D) && !head_drop;
  assign inst_rdata   = bus_rdata;
  assign data_rdata   = bus_rdata;

  // Lock onto the winner until the bus accepts its address.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (bus_req && !bus_addr_ok) state_nxt = (grant == OWN_I) ? LOCK_I : LOCK_D;
      end
      LOCK_I, LOCK_D: begin
        if (accept) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= IDLE;
    else         state <= state_nxt;
  end

`ifdef ARB_RR_EN
  // After a contested grant, favour the loser on the next conflict.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rr_data <= 1'b1;
    end else if (state == IDLE && bus_req && inst_req && data_req) begin
      rr_data <= (grant == OWN_I);
    end
  end
`endif

  owner_fifo #(
    .DEPTH (OUTST_DEPTH)
  ) u_owner_fifo (
    .clk        (clk),
    .resetn     (resetn),
    .push       (accept),
    .push_owner (grant),
    .pop        (bus_data_ok),
    .kill_inst  (inst_kill),
    .head_owner (head_owner),
    .head_drop  (head_drop),
    .count      (count)
  );

endmodule

// File: tb/tb_sram_bus_arbiter.sv
// Directed bench for sram_bus_arbiter (OUTST_DEPTH=2).
module tb_sram_bus_arbiter;

  logic        clk = 1'b0;
  logic        resetn;
  logic        inst_req, inst_addr_ok, inst_data_ok, inst_kill;
  logic [31:0] inst_addr, inst_rdata;
  logic        data_req, data_wr, data_addr_ok, data_data_ok;
  logic [1:0]  data_size;
  logic [31:0] data_addr, data_wdata, data_rdata;
  logic        bus_req, bus_wr, bus_addr_ok, bus_data_ok;
  logic [1:0]  bus_size;
  logic [31:0] bus_addr, bus_wdata, bus_rdata;

  int checks = 0;
  int failures = 0;
  logic rr;

  always #5 clk = ~clk;

  sram_bus_arbiter #(.OUTST_DEPTH(2)) dut (
    .clk(clk), .resetn(resetn),
    .inst_req(inst_req), .inst_addr(inst_addr), .inst_addr_ok(inst_addr_ok),
    .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata), .inst_kill(inst_kill),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size), .data_addr(data_addr),
    .data_wdata(data_wdata), .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok),
    .data_rdata(data_rdata),
    .bus_req(bus_req), .bus_wr(bus_wr), .bus_size(bus_size), .bus_addr(bus_addr),
    .bus_wdata(bus_wdata), .bus_addr_ok(bus_addr_ok), .bus_data_ok(bus_data_ok),
    .bus_rdata(bus_rdata)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    @(negedge clk);
  endtask

  function automatic logic [31:0] st();
    return 32'(dut.state);
  endfunction

  function automatic logic [31:0] cnt();
    return 32'(dut.count);
  endfunction

  initial begin
`ifdef ARB_RR_EN
    rr = 1'b1;
`else
    rr = 1'b0;
`endif
    resetn = 1'b0; inst_req = 1'b1; inst_addr = 32'hbfc00000; inst_kill = 1'b0;
    data_req = 1'b0; data_wr = 1'b0; data_size = 2'b10; data_addr = '0; data_wdata = '0;
    bus_addr_ok = 1'b1; bus_data_ok = 1'b1; bus_rdata = '0;
    #1;
    chk("rst_bus_req", bus_req, 0);
    chk("rst_iaok", inst_addr_ok, 0);
    chk("rst_idok", inst_data_ok, 0);
    chk("rst_ddok", data_data_ok, 0);
    chk("rst_count", cnt(), 0);
    chk("rst_state", st(), 0);
    repeat (2) @(negedge clk);
    resetn = 1'b1; inst_req = 1'b0; bus_addr_ok = 1'b0; bus_data_ok = 1'b0;
    step;

    // fetch only
    inst_req = 1'b1; inst_addr = 32'hbfc00000; bus_addr_ok = 1'b1; #1;
    chk("t1_bus_req", bus_req, 1);
    chk("t1_bus_addr", bus_addr, 32'hbfc00000);
    chk("t1_bus_size", bus_size, 2);
    chk("t1_bus_wr", bus_wr, 0);
    chk("t1_iaok", inst_addr_ok, 1);
    chk("t1_daok", data_addr_ok, 0);
    step; inst_req = 1'b0; bus_addr_ok = 1'b0; #1;
    chk("t1_state", st(), 0);
    chk("t1_count", cnt(), 1);
    chk("t1_idok_early", inst_data_ok, 0);
    step; bus_data_ok = 1'b1; bus_rdata = 32'h3c1d0000; #1;
    chk("t1_idok", inst_data_ok, 1);
    chk("t1_irdata", inst_rdata, 32'h3c1d0000);
    chk("t1_ddok", data_data_ok, 0);
    step; bus_data_ok = 1'b0; #1;
    chk("t1_count_end", cnt(), 0);

    // first conflict: data wins in both modes
    inst_req = 1'b1; inst_addr = 32'hbfc00004;
    data_req = 1'b1; data_wr = 1'b0; data_size = 2'b10; data_addr = 32'h80001000;
    bus_addr_ok = 1'b1; #1;
    chk("t2_bus_addr0", bus_addr, 32'h80001000);
    chk("t2_daok0", data_addr_ok, 1);
    chk("t2_iaok0", inst_addr_ok, 0);
    step; data_req = 1'b0; #1;
    chk("t2_bus_addr1", bus_addr, 32'hbfc00004);
    chk("t2_iaok1", inst_addr_ok, 1);
    chk("t2_count1", cnt(), 1);
    step; inst_req = 1'b0; bus_addr_ok = 1'b0; bus_data_ok = 1'b1; bus_rdata = 32'h11111111; #1;
    chk("t2_count2", cnt(), 2);
    chk("t2_ddok", data_data_ok, 1);
    chk("t2_idok", inst_data_ok, 0);
    chk("t2_drdata", data_rdata, 32'h11111111);
    step; bus_rdata = 32'h22222222; #1;
    chk("t2_idok2", inst_data_ok, 1);
    chk("t2_ddok2", data_data_ok, 0);
    step; bus_data_ok = 1'b0;

    // second conflict: fetch first only with round-robin
    inst_req = 1'b1; inst_addr = 32'hbfc00008;
    data_req = 1'b1; data_addr = 32'h80001004; bus_addr_ok = 1'b1; #1;
    chk("t2b_addr_first", bus_addr, rr ? 32'hbfc00008 : 32'h80001004);
    chk("t2b_iaok_first", inst_addr_ok, rr);
    chk("t2b_daok_first", data_addr_ok, !rr);
    step;
    if (rr) inst_req = 1'b0; else data_req = 1'b0;
    #1;
    chk("t2b_addr_second", bus_addr, rr ? 32'h80001004 : 32'hbfc00008);
    chk("t2b_iaok_second", inst_addr_ok, !rr);
    step; inst_req = 1'b0; data_req = 1'b0; bus_addr_ok = 1'b0; bus_data_ok = 1'b1; #1;
    chk("t2b_idok_first", inst_data_ok, rr);
    chk("t2b_ddok_first", data_data_ok, !rr);
    step; #1;
    chk("t2b_idok_second", inst_data_ok, !rr);
    chk("t2b_ddok_second", data_data_ok, rr);
    step; bus_data_ok = 1'b0;

    // lock: data granted, addr_ok withheld while fetch also requests
    data_req = 1'b1; data_addr = 32'h80001000; inst_req = 1'b1; inst_addr = 32'hbfc0000c;
    bus_addr_ok = 1'b0; #1;
    chk("t3_bus_req", bus_req, 1);
    chk("t3_bus_addr0", bus_addr, 32'h80001000);
    chk("t3_state0", st(), 0);
    for (int k = 0; k < 2; k++) begin
      step; #1;
      chk("t3_state_lock", st(), 2);
      chk("t3_bus_addr_lock", bus_addr, 32'h80001000);
      chk("t3_iaok_lock", inst_addr_ok, 0);
    end
    step; bus_addr_ok = 1'b1; #1;
    chk("t3_state_last", st(), 2);
    chk("t3_daok", data_addr_ok, 1);
    chk("t3_iaok", inst_addr_ok, 0);
    step; data_req = 1'b0; #1;
    chk("t3_state_idle", st(), 0);
    chk("t3_iaok_after", inst_addr_ok, 1);
    chk("t3_bus_addr_after", bus_addr, 32'hbfc0000c);
    step; inst_req = 1'b0; bus_addr_ok = 1'b0; bus_data_ok = 1'b1; #1;
    chk("t3_ddok", data_data_ok, 1);
    step; #1;
    chk("t3_idok", inst_data_ok, 1);
    step; bus_data_ok = 1'b0; #1;
    chk("t3_count_end", cnt(), 0);

    // full: two fetches outstanding, a same-cycle response must not open a slot
    inst_req = 1'b1; inst_addr = 32'hbfc00010; bus_addr_ok = 1'b1; #1;
    chk("t4_iaok0", inst_addr_ok, 1);
    step; inst_addr = 32'hbfc00014; #1;
    chk("t4_iaok1", inst_addr_ok, 1);
    chk("t4_count1", cnt(), 1);
    step; inst_req = 1'b0;
    data_req = 1'b1; data_wr = 1'b1; data_addr = 32'h80002000; data_wdata = 32'hdeadbeef;
    bus_data_ok = 1'b1; bus_rdata = 32'h33333333; #1;
    chk("t4_count_full", cnt(), 2);
    chk("t4_bus_req_full", bus_req, 0);
    chk("t4_daok_full", data_addr_ok, 0);
    chk("t4_idok_full", inst_data_ok, 1);
    step; bus_data_ok = 1'b0; #1;
    chk("t4_count_after", cnt(), 1);
    chk("t4_bus_req", bus_req, 1);
    chk("t4_daok", data_addr_ok, 1);
    chk("t4_bus_wr", bus_wr, 1);
    chk("t4_bus_wdata", bus_wdata, 32'hdeadbeef);
    step; data_req = 1'b0; data_wr = 1'b0; bus_addr_ok = 1'b0; #1;
    chk("t4_count2", cnt(), 2);
    bus_data_ok = 1'b1; #1;
    chk("t4_idok2", inst_data_ok, 1);
    step; #1;
    chk("t4_ddok", data_data_ok, 1);
    step; bus_data_ok = 1'b0; #1;
    chk("t4_count_end", cnt(), 0);

    // kill: two fetches dropped, interleaved data entry still answered
    inst_req = 1'b1; inst_addr = 32'hbfc00020; bus_addr_ok = 1'b1;
    step; inst_addr = 32'hbfc00024;
    step; inst_req = 1'b0; bus_addr_ok = 1'b0; inst_kill = 1'b1; #1;
    chk("t5_count", cnt(), 2);
    step; inst_kill = 1'b0; bus_data_ok = 1'b1; bus_rdata = 32'h44444444;
    data_req = 1'b1; data_wr = 1'b0; data_addr = 32'h80003000; bus_addr_ok = 1'b1; #1;
    chk("t5_idok0", inst_data_ok, 0);
    chk("t5_bus_req_full", bus_req, 0);
    chk("t5_daok_full", data_addr_ok, 0);
    step; #1;
    chk("t5_daok", data_addr_ok, 1);
    chk("t5_idok1", inst_data_ok, 0);
    chk("t5_count1", cnt(), 1);
    step; data_req = 1'b0; bus_addr_ok = 1'b0; bus_rdata = 32'h55555555; #1;
    chk("t5_ddok", data_data_ok, 1);
    chk("t5_drdata", data_rdata, 32'h55555555);
    chk("t5_idok2", inst_data_ok, 0);
    step; bus_data_ok = 1'b0; #1;
    chk("t5_count_end", cnt(), 0);

    // reset with two entries outstanding
    inst_req = 1'b1; inst_addr = 32'hbfc00030; bus_addr_ok = 1'b1;
    step; inst_addr = 32'hbfc00034;
    step; inst_req = 1'b0; bus_addr_ok = 1'b0; #1;
    chk("t6_count_pre", cnt(), 2);
    resetn = 1'b0; bus_data_ok = 1'b1; #1;
    chk("t6_count_rst", cnt(), 0);
    chk("t6_state_rst", st(), 0);
    chk("t6_idok_rst", inst_data_ok, 0);
    chk("t6_ddok_rst", data_data_ok, 0);
    step; resetn = 1'b1; bus_data_ok = 1'b0;
    step; inst_req = 1'b1; inst_addr = 32'hbfc00040; bus_addr_ok = 1'b1; #1;
    chk("t6_iaok", inst_addr_ok, 1);
    chk("t6_bus_addr", bus_addr, 32'hbfc00040);
    step; inst_req = 1'b0; bus_addr_ok = 1'b0; bus_data_ok = 1'b1; bus_rdata = 32'h66666666; #1;
    chk("t6_idok", inst_data_ok, 1);
    chk("t6_irdata", inst_rdata, 32'h66666666);
    step; bus_data_ok = 1'b0; #1;
    chk("t6_count_end", cnt(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
